// File: rtl/stats_frame_tx.sv
// stats_frame_tx
// Collects up to MAX_N 8-bit samples and, on start, presents a frame on a
// slow parallel output (one word held for HOLD_CYCLES clocks each):
//   header = sample count, then samples 0..count-1, then {6'b0, mode}.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_en, wr_data      append a sample (IDLE only, dropped when full)
//   clr                 empty the buffer (IDLE only, wins over wr_en)
//   mode, start         start a frame; mode latched at start
//   word, word_valid    presented word, pulse on first cycle of each word
//   busy, done          frame in progress, one-cycle pulse at frame end
//   count, full         number of stored samples, count == MAX_N
module stats_frame_tx #(
    parameter int unsigned HOLD_CYCLES = 1000000000,
    parameter int unsigned MAX_N       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic [1:0] mode,
    input  logic       start,
    output logic [7:0] word,
    output logic       word_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    output logic       full
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, MODE} state_t;

    localparam logic [3:0]  MAXC   = 4'(MAX_N);
    localparam logic [31:0] RELOAD = 32'(HOLD_CYCLES - 1);

    state_t      state, nstate;
    logic [7:0]  smp [MAX_N];
    logic [31:0] timer, n_timer;
    logic [3:0]  idx, n_idx;
    logic [3:0]  lat_cnt, n_lat_cnt;
    logic [1:0]  lat_mode, n_lat_mode;
    logic [3:0]  n_count;
    logic [7:0]  n_word;
    logic        n_wv, n_done, smp_we;

    assign busy = (state != IDLE);
    assign full = (count == MAXC);

    // State and all output registers; reset clears everything but the
    // sample storage, whose contents are meaningless once count is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            lat_cnt    <= '0;
            lat_mode   <= '0;
            count      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nstate;
            timer      <= n_timer;
            idx        <= n_idx;
            lat_cnt    <= n_lat_cnt;
            lat_mode   <= n_lat_mode;
            count      <= n_count;
            word       <= n_word;
            word_valid <= n_wv;
            done       <= n_done;
        end
    end

    always_ff @(posedge clk) begin
        if (smp_we) smp[count] <= wr_data;
    end

    always_comb begin
        nstate     = state;
        n_timer    = timer;
        n_idx      = idx;
        n_lat_cnt  = lat_cnt;
        n_lat_mode = lat_mode;
        n_count    = count;
        n_word     = word;
        n_wv       = 1'b0;
        n_done     = 1'b0;
        smp_we     = 1'b0;

        case (state)
            IDLE: begin
                n_word = '0;
                // start beats both clr and wr_en; an empty buffer makes start a no-op
                if (start && count != '0) begin
                    nstate     = HDR;
                    n_lat_cnt  = count;
                    n_lat_mode = mode;
                    n_word     = {4'b0, count};
                    n_wv       = 1'b1;
                    n_timer    = RELOAD;
                    n_idx      = '0;
                end else if (clr) begin
                    n_count = '0;
                end else if (wr_en && count < MAXC) begin
                    smp_we  = 1'b1;
                    n_count = count + 4'd1;
                end
            end
            default: begin
                if (timer != '0) begin
                    n_timer = timer - 32'd1;
                end else begin
                    // word boundary: move on and reload the hold timer
                    n_timer = RELOAD;
                    n_wv    = 1'b1;
                    case (state)
                        HDR: begin
                            nstate = DATA;
                            n_word = smp[0];
                            n_idx  = 4'd1;
                        end
                        DATA: begin
                            if (idx == lat_cnt) begin
                                nstate = MODE;
                                n_word = {6'b0, lat_mode};
                            end else begin
                                n_word = smp[idx];
                                n_idx  = idx + 4'd1;
                            end
                        end
                        default: begin
                            nstate  = IDLE;
                            n_word  = '0;
                            n_wv    = 1'b0;
                            n_done  = 1'b1;
                            n_timer = '0;
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_stats_frame_tx.sv
module tb_stats_frame_tx;

    localparam int H = 4;

    logic       clk = 0, rst_n = 0;
    logic       wr_en = 0, clr = 0, start = 0;
    logic [7:0] wr_data = 0;
    logic [1:0] mode = 0;
    logic [7:0] word;
    logic       word_valid, busy, done, full;
    logic [3:0] count;

    stats_frame_tx #(.HOLD_CYCLES(H), .MAX_N(10)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr(clr), .mode(mode), .start(start), .word(word),
        .word_valid(word_valid), .busy(busy), .done(done),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] d;
        logic       clr;
        logic [3:0] exp_cnt;
        logic       exp_full;
    } vec_t;

    vec_t       vt [0:19];
    logic [7:0] mdl [$];   // reference copy of the sample buffer
    logic [7:0] sb  [$];   // expected frame words
    int         vec_n = 0, miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            wr_en = vt[i].wr_en; wr_data = vt[i].d; clr = vt[i].clr;
            @(posedge clk); #1;
            wr_en = 0; clr = 0;
            if (vt[i].clr) mdl.delete();
            else if (vt[i].wr_en && mdl.size() < 10) mdl.push_back(vt[i].d);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(vt[i].exp_full));
        end
    endtask

    // Issue start and check every cycle of the frame. Words come from the
    // scoreboard, popped when a new word is due. abort_k >= 0 pulls reset
    // in the middle of that cycle.
    task automatic run_frame(input logic [1:0] m, input bit inject, input int abort_k);
        int n, total;
        logic [7:0] cur;
        n = mdl.size();
        total = (n + 2) * H;
        cur = 0;
        sb.push_back(8'(n));
        foreach (mdl[i]) sb.push_back(mdl[i]);
        sb.push_back({6'b0, m});
        @(negedge clk);
        mode = m; start = 1;
        @(posedge clk); #1;
        start = 0;
        mode = m + 2'd1;   // must not affect the running frame
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            if (k < total && k % H == 0) begin
                if (sb.size() == 0) chk("sb underflow", 1, 0);
                else cur = sb.pop_front();
            end
            chk($sformatf("k%0d word", k), 32'(word), (k < total) ? 32'(cur) : 0);
            chk($sformatf("k%0d word_valid", k), 32'(word_valid), 32'(k < total && k % H == 0));
            chk($sformatf("k%0d busy", k), 32'(busy), 32'(k < total));
            chk($sformatf("k%0d done", k), 32'(done), 32'(k == total));
            if (inject && k == 5) begin
                wr_en = 1; wr_data = 8'hAA; clr = 1; start = 1; mode = 2'd3;
            end
            if (inject && k == 6) begin
                wr_en = 0; clr = 0; start = 0;
            end
            if (k == abort_k) begin
                #2 rst_n = 0;
                #1;
                chk("rst word", 32'(word), 0);
                chk("rst word_valid", 32'(word_valid), 0);
                chk("rst busy", 32'(busy), 0);
                chk("rst done", 32'(done), 0);
                chk("rst count", 32'(count), 0);
                chk("rst full", 32'(full), 0);
                sb.delete();
                mdl.delete();
                @(negedge clk);
                rst_n = 1;
                break;
            end
        end
        chk("sb drained", 32'(sb.size()), 0);
    endtask

    initial begin
        vt[0]  = '{0, 8'd0, 1, 4'd0, 0};
        vt[1]  = '{1, 8'd5, 0, 4'd1, 0};
        vt[2]  = '{1, 8'd7, 0, 4'd2, 0};
        vt[3]  = '{1, 8'd9, 0, 4'd3, 0};
        vt[4]  = '{1, 8'd4, 1, 4'd0, 0};   // clr beats wr_en
        for (int i = 0; i < 11; i++)
            vt[5+i] = '{1, 8'(i + 1), 0, 4'((i < 10) ? i + 1 : 10), (i >= 9)};
        vt[16] = '{0, 8'd0, 1, 4'd0, 0};
        vt[17] = '{1, 8'd5, 0, 4'd1, 0};
        vt[18] = '{1, 8'd7, 0, 4'd2, 0};
        vt[19] = '{1, 8'd9, 0, 4'd3, 0};

        #1;
        chk("reset word", 32'(word), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset count", 32'(count), 0);
        chk("reset full", 32'(full), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // 5,7,9 in mode 2, then retransmit in mode 1 with mid-frame noise
        run_vecs(0, 3);
        run_frame(2'd2, 0, -1);
        run_frame(2'd1, 1, -1);
        chk("count after noisy frame", 32'(count), 3);

        // clr+wr_en, then overfill
        run_vecs(4, 15);
        run_frame(2'd0, 0, -1);

        // start with empty buffer is ignored
        run_vecs(16, 16);
        @(negedge clk); start = 1;
        @(posedge clk); #1; start = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("empty busy", 32'(busy), 0);
            chk("empty word_valid", 32'(word_valid), 0);
            chk("empty done", 32'(done), 0);
            chk("empty word", 32'(word), 0);
        end

        // reset during the third data word
        run_vecs(17, 19);
        run_frame(2'd2, 0, 13);
        chk("count after reset", 32'(count), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post-reset done", 32'(done), 0);
            chk("post-reset busy", 32'(busy), 0);
        end

        // accepts writes immediately after reset release
        run_vecs(17, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss);
        $finish;
    end

endmodule
